// File: rtl/vga_mode_pkg.sv
// rtl/vga_mode_pkg.sv - 640x480@60 raster timing constants and derived sync window bounds
package vga_mode_pkg;

  localparam int H_VISIBLE     = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_BACK_PORCH  = 48;
  localparam int H_WHOLE_LINE  = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

  localparam int V_VISIBLE     = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_BACK_PORCH  = 33;
  localparam int V_WHOLE_FRAME = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam int H_SYNC_START  = H_VISIBLE + H_FRONT_PORCH;
  localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_PULSE;
  localparam int V_SYNC_START  = V_VISIBLE + V_FRONT_PORCH;
  localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_PULSE;

  localparam bit SYNC_ACTIVE   = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter plus registered sync window
module vga_axis_counter #(
  parameter int WHOLE       = 800,
  parameter int SYNC_START  = 656,
  parameter int SYNC_END    = 752,
  parameter int WIDTH       = 10,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(WHOLE - 1);
  localparam logic [WIDTH-1:0] S_BEG = WIDTH'(SYNC_START);
  localparam logic [WIDTH-1:0] S_END = WIDTH'(SYNC_END);

  logic [WIDTH-1:0] count_next;

  // Terminal-count flag; the caller qualifies it with its own increment.
  assign wrap = (count == LAST);

  always_comb begin
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      sync  <= ~SYNC_ACTIVE;
    end else begin
      count <= count_next;
      sync  <= (count_next >= S_BEG && count_next < S_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator: column/row counters, syncs, visible and start pulses
module vga_sync_gen
  import vga_mode_pkg::*;
#(
  parameter int H_VISIBLE     = vga_mode_pkg::H_VISIBLE,
  parameter int H_FRONT_PORCH = vga_mode_pkg::H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = vga_mode_pkg::H_SYNC_PULSE,
  parameter int H_BACK_PORCH  = vga_mode_pkg::H_BACK_PORCH,
  parameter int V_VISIBLE     = vga_mode_pkg::V_VISIBLE,
  parameter int V_FRONT_PORCH = vga_mode_pkg::V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = vga_mode_pkg::V_SYNC_PULSE,
  parameter int V_BACK_PORCH  = vga_mode_pkg::V_BACK_PORCH,
  parameter bit SYNC_ACTIVE   = vga_mode_pkg::SYNC_ACTIVE,
  localparam int H_WHOLE_LINE  = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE_FRAME = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int COLUMN_BITS   = $clog2(H_WHOLE_LINE),
  localparam int ROW_BITS      = $clog2(V_WHOLE_FRAME)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pixel_en,
  output logic [COLUMN_BITS-1:0] column,
  output logic [ROW_BITS-1:0]    row,
  output logic                   visible,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int HS_BEG = H_VISIBLE + H_FRONT_PORCH;
  localparam int VS_BEG = V_VISIBLE + V_FRONT_PORCH;
  localparam logic [COLUMN_BITS-1:0] H_VIS = COLUMN_BITS'(H_VISIBLE);
  localparam logic [ROW_BITS-1:0]    V_VIS = ROW_BITS'(V_VISIBLE);

  if (H_FRONT_PORCH < 1 || H_SYNC_PULSE < 1 || H_BACK_PORCH < 1 ||
      V_FRONT_PORCH < 1 || V_SYNC_PULSE < 1 || V_BACK_PORCH < 1) begin : g_bad_porch
    $error("vga_sync_gen: every porch and sync pulse must be at least 1");
  end
  if (H_WHOLE_LINE > (1 << COLUMN_BITS) || V_WHOLE_FRAME > (1 << ROW_BITS)) begin : g_bad_width
    $error("vga_sync_gen: whole line/frame does not fit the counter width");
  end

  logic                   primed;
  logic                   first;
  logic                   h_inc;
  logic                   h_wrap;
  logic                   v_inc;
  logic                   v_wrap;
  logic [COLUMN_BITS-1:0] column_next;
  logic [ROW_BITS-1:0]    row_next;

  // The first enabled edge after reset presents 0/0 with both start pulses
  // instead of advancing, so consumers see a complete first pixel.
  assign first = pixel_en & ~primed;
  assign h_inc = pixel_en & primed;
  assign v_inc = h_inc & h_wrap;

  vga_axis_counter #(
    .WHOLE(H_WHOLE_LINE), .SYNC_START(HS_BEG), .SYNC_END(HS_BEG + H_SYNC_PULSE),
    .WIDTH(COLUMN_BITS), .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_h (
    .clk(clk), .reset_n(reset_n), .inc(h_inc),
    .count(column), .wrap(h_wrap), .sync(hsync)
  );

  vga_axis_counter #(
    .WHOLE(V_WHOLE_FRAME), .SYNC_START(VS_BEG), .SYNC_END(VS_BEG + V_SYNC_PULSE),
    .WIDTH(ROW_BITS), .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_v (
    .clk(clk), .reset_n(reset_n), .inc(v_inc),
    .count(row), .wrap(v_wrap), .sync(vsync)
  );

  always_comb begin
    column_next = column;
    row_next    = row;
    if (h_inc) begin
      column_next = h_wrap ? '0 : column + COLUMN_BITS'(1);
    end
    if (v_inc) begin
      row_next = v_wrap ? '0 : row + ROW_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      primed      <= 1'b0;
      visible     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      primed      <= primed | pixel_en;
      visible     <= (column_next < H_VIS) && (row_next < V_VIS);
      line_start  <= first | v_inc;
      frame_start <= first | (v_inc & v_wrap);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: full 640x480 instance plus a reduced-mode instance for frame checks
module tb_vga_sync_gen;

  logic       clk;
  logic       reset_n;
  logic       pixel_en;
  logic [9:0] column;
  logic [9:0] row;
  logic       visible, hsync, vsync, line_start, frame_start;

  logic [4:0] s_column;
  logic [3:0] s_row;
  logic       s_visible, s_hsync, s_vsync, s_line_start, s_frame_start;

  int tests = 0;
  int fails = 0;

  vga_sync_gen dut (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .column(column), .row(row), .visible(visible), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  // 24 x 12 raster: visible 16x6, hsync cols 18..20, vsync rows 8..9, frame 288 clk
  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
    .V_VISIBLE(6), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(2), .SYNC_ACTIVE(1'b0)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .column(s_column), .row(s_row), .visible(s_visible), .hsync(s_hsync), .vsync(s_vsync),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    repeat (3) step();
    tests++; if (column !== 10'd0) begin fails++; $display("FAIL reset_column got %0d want 0", column); end
    tests++; if (row !== 10'd0) begin fails++; $display("FAIL reset_row got %0d want 0", row); end
    tests++; if (hsync !== 1'b1 || vsync !== 1'b1) begin fails++; $display("FAIL reset_sync got h%b v%b want h1 v1", hsync, vsync); end
    tests++; if (visible !== 1'b1) begin fails++; $display("FAIL reset_visible got %b want 1", visible); end
    tests++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin fails++; $display("FAIL reset_pulses got ls%b fs%b want 0 0", line_start, frame_start); end
    tests++; if (s_column !== 5'd0 || s_hsync !== 1'b1) begin fails++; $display("FAIL reset_small got col%0d h%b want 0 1", s_column, s_hsync); end
  endtask

  task automatic test_first_frame();
    reset_n = 1'b1;
    step();
    tests++; if (column !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL first_pos got %0d/%0d want 0/0", column, row); end
    tests++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin fails++; $display("FAIL first_pulses got fs%b ls%b want 1 1", frame_start, line_start); end
    tests++; if (s_frame_start !== 1'b1) begin fails++; $display("FAIL first_small_fs got %b want 1", s_frame_start); end
    step();
    tests++; if (column !== 10'd1 || frame_start !== 1'b0 || line_start !== 1'b0) begin fails++; $display("FAIL first_advance got col%0d fs%b ls%b want 1 0 0", column, frame_start, line_start); end
  endtask

  task automatic test_line_timing();
    int lo_cnt = 0, lo_first = -1, lo_last = -1, vis_fall = -1, guard = 0;
    bit prev_vis = 1'b1;
    while (int'(column) != 799 && guard < 1000) begin
      step();
      guard++;
      if (hsync == 1'b0) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(column);
        lo_last = int'(column);
      end
      if (prev_vis && !visible && vis_fall < 0) vis_fall = int'(column);
      prev_vis = visible;
    end
    tests++; if (guard >= 1000) begin fails++; $display("FAIL line_timeout got %0d steps want <1000", guard); end
    tests++; if (lo_cnt !== 96) begin fails++; $display("FAIL hsync_width got %0d want 96", lo_cnt); end
    tests++; if (lo_first !== 656 || lo_last !== 751) begin fails++; $display("FAIL hsync_window got %0d..%0d want 656..751", lo_first, lo_last); end
    tests++; if (vis_fall !== 640) begin fails++; $display("FAIL visible_fall got %0d want 640", vis_fall); end
    step();
    tests++; if (column !== 10'd0 || row !== 10'd1) begin fails++; $display("FAIL line_wrap got %0d/%0d want 0/1", column, row); end
    tests++; if (line_start !== 1'b1 || frame_start !== 1'b0 || visible !== 1'b1) begin fails++; $display("FAIL line_wrap_flags got ls%b fs%b vis%b want 1 0 1", line_start, frame_start, visible); end
    step();
    tests++; if (line_start !== 1'b0 || column !== 10'd1) begin fails++; $display("FAIL line_pulse_len got ls%b col%0d want 0 1", line_start, column); end
  endtask

  task automatic test_enable_gating();
    int first_ls = -1, second_ls = -1, holds_bad = 0, pulse_long = 0;
    bit pe = 1'b0;
    bit prev_ls;
    logic [9:0] prev_col;
    for (int i = 0; i < 4000 && second_ls < 0; i++) begin
      pe = ~pe;
      pixel_en = pe;
      prev_col = column;
      prev_ls = line_start;
      step();
      if (!pe && column !== prev_col) holds_bad++;
      if (prev_ls && line_start) pulse_long++;
      if (line_start) begin
        if (first_ls < 0) first_ls = i;
        else second_ls = i;
      end
    end
    pixel_en = 1'b1;
    tests++; if (second_ls < 0) begin fails++; $display("FAIL gated_timeout got first=%0d second=%0d want both seen", first_ls, second_ls); end
    tests++; if (second_ls - first_ls !== 1600) begin fails++; $display("FAIL gated_line_period got %0d want 1600", second_ls - first_ls); end
    tests++; if (holds_bad !== 0) begin fails++; $display("FAIL gated_hold got %0d moves want 0", holds_bad); end
    tests++; if (pulse_long !== 0) begin fails++; $display("FAIL gated_pulse_len got %0d long pulses want 0", pulse_long); end
  endtask

  task automatic test_vsync_frame();
    int guard = 0, period = 0, lo_cnt = 0;
    int lo_first_row = -1, lo_first_col = -1, lo_last_row = -1, lo_last_col = -1;
    int prev_row = -1, prev_col = -1;
    while (!s_frame_start && guard < 400) begin
      step();
      guard++;
    end
    tests++; if (guard >= 400) begin fails++; $display("FAIL vsync_sync_timeout got %0d want <400", guard); end
    for (int i = 1; i <= 400; i++) begin
      prev_row = int'(s_row);
      prev_col = int'(s_column);
      step();
      if (s_frame_start) begin
        period = i;
        break;
      end
      if (!s_vsync) begin
        lo_cnt++;
        if (lo_first_row < 0) begin lo_first_row = int'(s_row); lo_first_col = int'(s_column); end
        lo_last_row = int'(s_row);
        lo_last_col = int'(s_column);
      end
    end
    tests++; if (period !== 288) begin fails++; $display("FAIL frame_period got %0d want 288", period); end
    tests++; if (lo_cnt !== 48) begin fails++; $display("FAIL vsync_width got %0d want 48", lo_cnt); end
    tests++; if (lo_first_row !== 8 || lo_first_col !== 0) begin fails++; $display("FAIL vsync_fall got r%0d c%0d want r8 c0", lo_first_row, lo_first_col); end
    tests++; if (lo_last_row !== 9 || lo_last_col !== 23) begin fails++; $display("FAIL vsync_rise got r%0d c%0d want r9 c23", lo_last_row, lo_last_col); end
    tests++; if (prev_row !== 11 || prev_col !== 23) begin fails++; $display("FAIL frame_wrap_from got r%0d c%0d want r11 c23", prev_row, prev_col); end
    tests++; if (s_row !== 4'd0 || s_column !== 5'd0 || s_line_start !== 1'b1 || s_visible !== 1'b1) begin fails++; $display("FAIL frame_wrap_to got r%0d c%0d ls%b vis%b want 0 0 1 1", s_row, s_column, s_line_start, s_visible); end
  endtask

  task automatic test_mid_frame_reset();
    int guard = 0;
    int target_row;
    target_row = int'(row) + 1;
    while (!(int'(row) == target_row && int'(column) == 123) && guard < 2000) begin
      step();
      guard++;
    end
    tests++; if (guard >= 2000) begin fails++; $display("FAIL midreset_timeout got %0d want <2000", guard); end
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    step();
    tests++; if (column !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL midreset_pos got %0d/%0d want 0/0", column, row); end
    tests++; if (frame_start !== 1'b0 || hsync !== 1'b1 || visible !== 1'b1) begin fails++; $display("FAIL midreset_flags got fs%b h%b vis%b want 0 1 1", frame_start, hsync, visible); end
    reset_n  = 1'b1;
    pixel_en = 1'b0;
    step();
    tests++; if (frame_start !== 1'b0 || column !== 10'd0) begin fails++; $display("FAIL midreset_idle got fs%b col%0d want 0 0", frame_start, column); end
    pixel_en = 1'b1;
    step();
    tests++; if (frame_start !== 1'b1 || column !== 10'd0 || row !== 10'd0) begin fails++; $display("FAIL midreset_first got fs%b %0d/%0d want 1 0/0", frame_start, column, row); end
    step();
    tests++; if (frame_start !== 1'b0 || column !== 10'd1) begin fails++; $display("FAIL midreset_run got fs%b col%0d want 0 1", frame_start, column); end
  endtask

  initial begin
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    test_reset();
    test_first_frame();
    test_line_timing();
    test_enable_gating();
    test_vsync_frame();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
